// File: rtl/mc_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcWrite;
  logic       irWrite;
  logic       memWrite;
  logic       regWrite;
  logic [1:0] pcSrc;
  logic [2:0] aluControl;
  logic [1:0] aluSrc;
  logic [1:0] regDst;
  logic [2:0] memtoReg;
  logic [2:0] state;
  logic       retire;

  modport master (
    input  op, funct, zero,
    output pcWrite, irWrite, memWrite, regWrite, pcSrc, aluControl,
           aluSrc, regDst, memtoReg, state, retire
  );

  modport slave (
    output op, funct, zero,
    input  pcWrite, irWrite, memWrite, regWrite, pcSrc, aluControl,
           aluSrc, regDst, memtoReg, state, retire
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencer.
// Define MC_JUMP_EN to support jal and jr; otherwise they retire as 2-cycle nops.
module mc_controller (
  input  logic             clk,
  input  logic             reset,
  mc_controller_if.master  bus
);

`ifdef MC_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_NONE, I_ADDU, I_SUBU, I_JR, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_JAL
  } instr_t;

  state_t     state_q, state_d;
  instr_t     kind;
  logic [2:0] alu_ctl;
  logic [1:0] alu_src;

  always_comb begin
    kind = I_NONE;
    case (bus.op)
      6'h00: begin
        case (bus.funct)
          6'h21:   kind = I_ADDU;
          6'h23:   kind = I_SUBU;
          6'h08:   if (JUMP_EN) kind = I_JR;
          default: kind = I_NONE;
        endcase
      end
      6'h0D:   kind = I_ORI;
      6'h23:   kind = I_LW;
      6'h2B:   kind = I_SW;
      6'h04:   kind = I_BEQ;
      6'h0F:   kind = I_LUI;
      6'h03:   if (JUMP_EN) kind = I_JAL;
      default: kind = I_NONE;
    endcase
  end

  // No ALU output register in the datapath, so ALU selects persist through MEM and WB.
  always_comb begin
    alu_ctl = '0;
    alu_src = '0;
    case (kind)
      I_SUBU, I_BEQ: alu_ctl = 3'b001;
      I_ORI: begin
        alu_ctl = 3'b010;
        alu_src = 2'b10;
      end
      I_LW, I_SW:    alu_src = 2'b01;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = FETCH;
    bus.pcWrite    = 1'b0;
    bus.irWrite    = 1'b0;
    bus.memWrite   = 1'b0;
    bus.regWrite   = 1'b0;
    bus.pcSrc      = '0;
    bus.aluControl = '0;
    bus.aluSrc     = '0;
    bus.regDst     = '0;
    bus.memtoReg   = '0;
    bus.retire     = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          bus.irWrite = 1'b1;
          bus.pcWrite = 1'b1;
          state_d     = DECODE;
        end
        DECODE: begin
          if (kind == I_NONE) bus.retire = 1'b1;
          else                state_d    = EXEC;
        end
        EXEC: begin
          bus.aluControl = alu_ctl;
          bus.aluSrc     = alu_src;
          case (kind)
            I_ADDU, I_SUBU, I_ORI, I_LUI: state_d = WB;
            I_LW, I_SW:                   state_d = MEM;
            I_BEQ: begin
              bus.pcWrite = bus.zero;
              bus.pcSrc   = 2'b01;
              bus.retire  = 1'b1;
            end
            I_JAL: begin
              bus.pcWrite  = 1'b1;
              bus.pcSrc    = 2'b10;
              bus.regWrite = 1'b1;
              bus.regDst   = 2'b10;
              bus.memtoReg = 3'b100;
              bus.retire   = 1'b1;
            end
            I_JR: begin
              bus.pcWrite = 1'b1;
              bus.pcSrc   = 2'b11;
              bus.retire  = 1'b1;
            end
            default: ;
          endcase
        end
        MEM: begin
          bus.aluControl = alu_ctl;
          bus.aluSrc     = alu_src;
          if (kind == I_SW) begin
            bus.memWrite = 1'b1;
            bus.retire   = 1'b1;
          end else if (kind == I_LW) begin
            state_d = WB;
          end
        end
        WB: begin
          bus.aluControl = alu_ctl;
          bus.aluSrc     = alu_src;
          bus.regWrite   = 1'b1;
          bus.retire     = 1'b1;
          bus.regDst     = (kind == I_ADDU || kind == I_SUBU) ? 2'b01 : 2'b00;
          case (kind)
            I_LW:    bus.memtoReg = 3'b001;
            I_LUI:   bus.memtoReg = 3'b010;
            default: bus.memtoReg = 3'b000;
          endcase
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: vector table, reset corner cases and
// randomized instructions against a per-cycle behavioural model.
module tb_mc_controller;

`ifdef MC_JUMP_EN
  localparam bit JMP = 1'b1;
  localparam int JL  = 3;
`else
  localparam bit JMP = 1'b0;
  localparam int JL  = 2;
`endif

  logic clk = 1'b0;
  logic reset;
  mc_controller_if bus();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct packed {
    logic [2:0] state;
    logic       pcw, irw, memw, regw, retire;
    logic [1:0] pcsrc;
    logic [2:0] aluc;
    logic [1:0] alus;
    logic [1:0] regdst;
    logic [2:0] m2r;
  } outs_t;

  typedef enum {K_NOP, K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JAL, K_JR} kind_t;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    int          lat;
    logic [14:0] path;
    string       name;
  } vec_t;

  function automatic outs_t sample();
    outs_t o;
    o.state  = bus.state;
    o.pcw    = bus.pcWrite;
    o.irw    = bus.irWrite;
    o.memw   = bus.memWrite;
    o.regw   = bus.regWrite;
    o.retire = bus.retire;
    o.pcsrc  = bus.pcSrc;
    o.aluc   = bus.aluControl;
    o.alus   = bus.aluSrc;
    o.regdst = bus.regDst;
    o.m2r    = bus.memtoReg;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] funct);
    if (op == 6'h00 && funct == 6'h21) return K_ADDU;
    if (op == 6'h00 && funct == 6'h23) return K_SUBU;
    if (op == 6'h00 && funct == 6'h08 && JMP) return K_JR;
    if (op == 6'h0D) return K_ORI;
    if (op == 6'h23) return K_LW;
    if (op == 6'h2B) return K_SW;
    if (op == 6'h04) return K_BEQ;
    if (op == 6'h0F) return K_LUI;
    if (op == 6'h03 && JMP) return K_JAL;
    return K_NOP;
  endfunction

  function automatic int latency(input kind_t k);
    case (k)
      K_LW:                                 return 5;
      K_ADDU, K_SUBU, K_ORI, K_LUI, K_SW:   return 4;
      K_BEQ, K_JAL, K_JR:                   return 3;
      default:                              return 2;
    endcase
  endfunction

  // Expected outputs in cycle c (0 = fetch) of an instruction of kind k.
  function automatic outs_t model(input kind_t k, input int c, input logic z);
    outs_t o = '0;
    if (c == 0)      o.state = 3'd0;
    else if (c == 1) o.state = 3'd1;
    else if (c == 2) o.state = 3'd2;
    else if (c == 3) o.state = (k == K_LW || k == K_SW) ? 3'd3 : 3'd4;
    else             o.state = 3'd4;
    o.retire = (c == latency(k) - 1);
    if (o.state == 3'd0) begin
      o.irw = 1'b1;
      o.pcw = 1'b1;
    end
    if (o.state >= 3'd2) begin
      if (k == K_SUBU || k == K_BEQ) o.aluc = 3'b001;
      if (k == K_ORI) begin o.aluc = 3'b010; o.alus = 2'b10; end
      if (k == K_LW || k == K_SW) o.alus = 2'b01;
    end
    if (o.state == 3'd2 && k == K_BEQ) begin o.pcw = z; o.pcsrc = 2'b01; end
    if (o.state == 3'd2 && k == K_JAL) begin
      o.pcw = 1'b1; o.pcsrc = 2'b10; o.regw = 1'b1; o.regdst = 2'b10; o.m2r = 3'b100;
    end
    if (o.state == 3'd2 && k == K_JR) begin o.pcw = 1'b1; o.pcsrc = 2'b11; end
    if (o.state == 3'd3 && k == K_SW) o.memw = 1'b1;
    if (o.state == 3'd4) begin
      o.regw   = 1'b1;
      o.regdst = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
      if (k == K_LW)  o.m2r = 3'b001;
      if (k == K_LUI) o.m2r = 3'b010;
    end
    return o;
  endfunction

  // Starts inside a FETCH cycle; op/funct are garbage during FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input logic z,
                           input int lat, input logic [14:0] path, input bit use_path,
                           input string tag);
    kind_t k = classify(op, funct);
    for (int c = 0; c < lat; c++) begin
      if (c == 0) begin
        bus.op    = 6'($urandom);
        bus.funct = 6'($urandom);
        bus.zero  = 1'($urandom);
      end else begin
        bus.op    = op;
        bus.funct = funct;
        bus.zero  = z;
      end
      #1;
      chk($sformatf("%s c%0d outputs", tag, c), 32'(sample()), 32'(model(k, c, bus.zero)));
      if (use_path)
        chk($sformatf("%s c%0d state", tag, c), 32'(bus.state), 32'(path[3*c +: 3]));
      @(posedge clk); #1;
    end
    chk($sformatf("%s refetch", tag), 32'(bus.state), 32'd0);
  endtask

  vec_t tbl[$];
  logic [5:0] ops[12]  = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h0F,
                           6'h03, 6'h00, 6'h3F, 6'h00};
  logic [5:0] fns[12]  = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h11, 6'h22, 6'h3F, 6'h00,
                           6'h00, 6'h00, 6'h00, 6'h2A};

  initial begin
    tbl.push_back('{6'h23, 6'h00, 1'b0, 5,  {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, "lw"});
    tbl.push_back('{6'h00, 6'h21, 1'b0, 4,  {3'd0, 3'd4, 3'd2, 3'd1, 3'd0}, "addu"});
    tbl.push_back('{6'h00, 6'h23, 1'b1, 4,  {3'd0, 3'd4, 3'd2, 3'd1, 3'd0}, "subu"});
    tbl.push_back('{6'h0D, 6'h15, 1'b0, 4,  {3'd0, 3'd4, 3'd2, 3'd1, 3'd0}, "ori"});
    tbl.push_back('{6'h0F, 6'h00, 1'b0, 4,  {3'd0, 3'd4, 3'd2, 3'd1, 3'd0}, "lui"});
    tbl.push_back('{6'h2B, 6'h00, 1'b0, 4,  {3'd0, 3'd3, 3'd2, 3'd1, 3'd0}, "sw"});
    tbl.push_back('{6'h04, 6'h00, 1'b1, 3,  {3'd0, 3'd0, 3'd2, 3'd1, 3'd0}, "beq_taken"});
    tbl.push_back('{6'h04, 6'h00, 1'b0, 3,  {3'd0, 3'd0, 3'd2, 3'd1, 3'd0}, "beq_not"});
    tbl.push_back('{6'h03, 6'h00, 1'b0, JL, {3'd0, 3'd0, 3'd2, 3'd1, 3'd0}, "jal"});
    tbl.push_back('{6'h00, 6'h08, 1'b0, JL, {3'd0, 3'd0, 3'd2, 3'd1, 3'd0}, "jr"});
    tbl.push_back('{6'h00, 6'h00, 1'b0, 2,  {3'd0, 3'd0, 3'd0, 3'd1, 3'd0}, "sll_nop"});
    tbl.push_back('{6'h3F, 6'h00, 1'b0, 2,  {3'd0, 3'd0, 3'd0, 3'd1, 3'd0}, "op3f"});
    tbl.push_back('{6'h00, 6'h22, 1'b1, 2,  {3'd0, 3'd0, 3'd0, 3'd1, 3'd0}, "sub_unsup"});

    // Reset state: everything low, state FETCH, regardless of op.
    reset     = 1'b1;
    bus.op    = 6'h23;
    bus.funct = 6'h00;
    bus.zero  = 1'b0;
    #1;
    chk("reset outputs t1", 32'(sample()), 32'd0);
    @(posedge clk); #1;
    bus.op = 6'h2B;
    #1;
    chk("reset outputs held", 32'(sample()), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("post-reset fetch", 32'(sample()), 32'(model(K_NOP, 0, 1'b0)));

    foreach (tbl[i])
      run_instr(tbl[i].op, tbl[i].funct, tbl[i].zero, tbl[i].lat, tbl[i].path, 1'b1, tbl[i].name);

    // Reset asserted mid-cycle during sw MEM: abort immediately, refetch after release.
    bus.op = 6'h2B; bus.funct = 6'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sw mem state", 32'(bus.state), 32'd3);
    chk("sw mem write", 32'(bus.memWrite), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort outputs", 32'(sample()), 32'd0);
    @(posedge clk); #1;
    chk("abort hold", 32'(sample()), 32'd0);
    reset = 1'b0;
    #1;
    chk("abort refetch", 32'(sample()), 32'(model(K_NOP, 0, 1'b0)));
    bus.op = 6'h3F;
    @(posedge clk); #1;
    chk("abort decode", 32'(sample()), 32'(model(K_NOP, 1, 1'b0)));
    @(posedge clk); #1;
    chk("abort back to fetch", 32'(bus.state), 32'd0);

    for (int n = 0; n < 150; n++) begin
      logic [5:0] op, fn;
      int unsigned sel = $urandom_range(0, 14);
      if (sel < 12) begin
        op = ops[sel];
        fn = fns[sel];
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      run_instr(op, fn, 1'($urandom), latency(classify(op, fn)), '0, 1'b0,
                $sformatf("rand%0d op%02h fn%02h", n, op, fn));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
